// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the ID/EX operand stage and the ALU.
//   - ALU operation codes
//   - fwd_sel_e  : operand source select produced by the forwarding unit
//   - id_ex_t    : contents of the ID/EX pipeline register
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int ALU_OP_W  = 4;
    localparam int REG_IDX_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b1100;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // All-zero value of this struct is the bubble.
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      rs1_data;
        logic [XLEN-1:0]      rs2_data;
        logic [XLEN-1:0]      imm;
        logic                 alu_src;
        logic [ALU_OP_W-1:0]  operation;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
    } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage_if
// Bundles the ID-side instruction fields, the two forwarding sources and the
// EX-side outputs of the operand stage.
//   master : driven by the core around the stage (ID, EX/MEM, MEM/WB)
//   slave  : the operand stage itself
// ---------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic [DATA_WIDTH-1:0]     id_rs1_data;
    logic [DATA_WIDTH-1:0]     id_rs2_data;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic                      id_alu_src;
    logic [OPCODE_LENGTH-1:0]  id_operation;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      id_mem_write;
    logic                      hold;
    logic                      flush;
    logic                      exmem_reg_write;
    logic [REG_ADDR_WIDTH-1:0] exmem_rd;
    logic [DATA_WIDTH-1:0]     exmem_result;
    logic                      memwb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] memwb_rd;
    logic [DATA_WIDTH-1:0]     memwb_result;

    logic                      id_stall;
    logic                      ex_valid;
    logic [DATA_WIDTH-1:0]     SrcA;
    logic [DATA_WIDTH-1:0]     SrcB;
    logic [OPCODE_LENGTH-1:0]  Operation;
    logic [DATA_WIDTH-1:0]     ex_store_data;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_reg_write;
    logic                      ex_mem_read;
    logic                      ex_mem_write;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_alu_src, id_operation, id_reg_write, id_mem_read,
               id_mem_write, hold, flush, exmem_reg_write, exmem_rd,
               exmem_result, memwb_reg_write, memwb_rd, memwb_result,
        input  id_stall, ex_valid, SrcA, SrcB, Operation, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_alu_src, id_operation, id_reg_write, id_mem_read,
               id_mem_write, hold, flush, exmem_reg_write, exmem_rd,
               exmem_result, memwb_reg_write, memwb_rd, memwb_result,
        output id_stall, ex_valid, SrcA, SrcB, Operation, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );

endinterface

// File: rtl/forwarding_unit.sv
// ---------------------------------------------------------------------------
// forwarding_unit
// Combinational hazard comparator. Selects, for each latched source index,
// whether its value comes from EX/MEM, MEM/WB or the register file.
//   i_rs1, i_rs2            latched source indices
//   i_exmem_reg_write/_rd   EX/MEM forwarding source
//   i_memwb_reg_write/_rd   MEM/WB forwarding source
//   o_fwd_a, o_fwd_b        selects for rs1 / rs2
// ---------------------------------------------------------------------------
module forwarding_unit
    import riscv_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2,
    input  logic                      i_exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] i_exmem_rd,
    input  logic                      i_memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] i_memwb_rd,
    output fwd_sel_e                  o_fwd_a,
    output fwd_sel_e                  o_fwd_b
);

    // x0 is hardwired; a write to it must never be forwarded.
    logic w_exmem_live;
    logic w_memwb_live;
    logic w_ex_a, w_ex_b, w_wb_a, w_wb_b;

    assign w_exmem_live = i_exmem_reg_write && (i_exmem_rd != '0);
    assign w_memwb_live = i_memwb_reg_write && (i_memwb_rd != '0);

    assign w_ex_a = w_exmem_live && (i_exmem_rd == i_rs1);
    assign w_ex_b = w_exmem_live && (i_exmem_rd == i_rs2);
    assign w_wb_a = w_memwb_live && (i_memwb_rd == i_rs1);
    assign w_wb_b = w_memwb_live && (i_memwb_rd == i_rs2);

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        o_fwd_a = FWD_REG;
        o_fwd_b = FWD_REG;
        if (w_ex_a)      o_fwd_a = FWD_EXMEM;
        else if (w_wb_a) o_fwd_a = FWD_MEMWB;
        if (w_ex_b)      o_fwd_b = FWD_EXMEM;
        else if (w_wb_b) o_fwd_b = FWD_MEMWB;
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
// ID/EX pipeline register plus operand delivery for the ALU. Latches the
// decoded instruction, forwards from EX/MEM and MEM/WB, and inserts one
// bubble on a load-use hazard.
//   clk, reset_n  core clock (rising edge), async active-low reset
//   bus (slave)   ID fields, hold/flush, forwarding sources in;
//                 id_stall, ex_* fields and ALU operands out
// ---------------------------------------------------------------------------
module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    id_ex_operand_stage_if.slave  bus
);

    id_ex_t                    r_ex;
    id_ex_t                    w_id_fields;
    logic                      w_load_use;
    fwd_sel_e                  w_fwd_a;
    fwd_sel_e                  w_fwd_b;
    logic [DATA_WIDTH-1:0]     w_fwd_rs1;
    logic [DATA_WIDTH-1:0]     w_fwd_rs2;
    logic [OPCODE_LENGTH-1:0]  w_ex_op;
    logic [REG_ADDR_WIDTH-1:0] w_ex_rd;

    always_comb begin
        w_id_fields           = '0;
        w_id_fields.valid     = bus.id_valid;
        w_id_fields.rs1       = bus.id_rs1;
        w_id_fields.rs2       = bus.id_rs2;
        w_id_fields.rd        = bus.id_rd;
        w_id_fields.rs1_data  = bus.id_rs1_data;
        w_id_fields.rs2_data  = bus.id_rs2_data;
        w_id_fields.imm       = bus.id_imm;
        w_id_fields.alu_src   = bus.id_alu_src;
        w_id_fields.operation = bus.id_operation;
        w_id_fields.reg_write = bus.id_reg_write;
        w_id_fields.mem_read  = bus.id_mem_read;
        w_id_fields.mem_write = bus.id_mem_write;
    end

    // A load in EX whose destination is read by the instruction in ID.
    assign w_load_use = r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) &&
                        bus.id_valid &&
                        ((bus.id_rs1 == r_ex.rd) || (bus.id_rs2 == r_ex.rd));

    // Priority: flush > hold > load-use bubble > load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex <= '0;
        end else if (bus.flush) begin
            r_ex <= '0;
        end else if (!bus.hold) begin
            if (w_load_use) r_ex <= '0;
            else            r_ex <= w_id_fields;
        end
    end

    forwarding_unit #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_forwarding_unit (
        .i_rs1             (r_ex.rs1),
        .i_rs2             (r_ex.rs2),
        .i_exmem_reg_write (bus.exmem_reg_write),
        .i_exmem_rd        (bus.exmem_rd),
        .i_memwb_reg_write (bus.memwb_reg_write),
        .i_memwb_rd        (bus.memwb_rd),
        .o_fwd_a           (w_fwd_a),
        .o_fwd_b           (w_fwd_b)
    );

    always_comb begin
        case (w_fwd_a)
            FWD_EXMEM: w_fwd_rs1 = bus.exmem_result;
            FWD_MEMWB: w_fwd_rs1 = bus.memwb_result;
            default:   w_fwd_rs1 = r_ex.rs1_data;
        endcase
        case (w_fwd_b)
            FWD_EXMEM: w_fwd_rs2 = bus.exmem_result;
            FWD_MEMWB: w_fwd_rs2 = bus.memwb_result;
            default:   w_fwd_rs2 = r_ex.rs2_data;
        endcase
    end

    assign w_ex_op = r_ex.operation;
    assign w_ex_rd = r_ex.rd;

    assign bus.id_stall      = w_load_use;
    assign bus.ex_valid      = r_ex.valid;
    assign bus.SrcA          = w_fwd_rs1;
    assign bus.SrcB          = r_ex.alu_src ? r_ex.imm : w_fwd_rs2;
    assign bus.Operation     = w_ex_op;
    assign bus.ex_store_data = w_fwd_rs2;
    assign bus.ex_rd         = w_ex_rd;
    // A latched non-valid slot must not write anything downstream.
    assign bus.ex_reg_write  = r_ex.valid && r_ex.reg_write;
    assign bus.ex_mem_read   = r_ex.valid && r_ex.mem_read;
    assign bus.ex_mem_write  = r_ex.valid && r_ex.mem_write;

endmodule
